// File: rtl/frac_dec_div.sv
// Sequential signed divider: 2W-bit dividend by W-bit divisor, truncating toward zero.
// Restoring shift-subtract, one quotient bit per clock, start/busy/done handshake.
module frac_dec_div #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [2*DATA_WIDTH-1:0]   dividend_i,
    input  logic [DATA_WIDTH-1:0]     divisor_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [DATA_WIDTH-1:0]     quotient_o,
    output logic [DATA_WIDTH-1:0]     remainder_o,
    output logic                      overflow_o,
    output logic                      div_by_zero_o
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MaxPos   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MinNeg   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] LastIter = W'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

    state_e         state_q, state_d;
    logic           done_q, done_d;
    logic [W-1:0]   quot_q, quot_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           ovf_q, ovf_d;
    logic           dbz_q, dbz_d;
    logic           sq_q, sq_d;
    logic           sr_q, sr_d;
    logic           excOvf_q, excOvf_d;
    logic           excDbz_q, excDbz_d;
    logic [W:0]     partial_q, partial_d;
    logic [W-1:0]   dvdLow_q, dvdLow_d;
    logic [W-1:0]   dvsMag_q, dvsMag_d;
    logic [W-1:0]   qMag_q, qMag_d;
    logic [W-1:0]   cnt_q, cnt_d;

    logic [2*W-1:0] dvdAbs;
    logic [W-1:0]   dvsAbs;
    logic           capDbz;
    logic           capOvf;
    logic [W:0]     shifted;
    logic           geq;
    logic           lateOvf;

    // Most-negative inputs negate to themselves, which is the correct unsigned magnitude.
    assign dvdAbs  = dividend_i[2*W-1] ? -dividend_i : dividend_i;
    assign dvsAbs  = divisor_i[W-1] ? -divisor_i : divisor_i;
    assign capDbz  = (divisor_i == '0);
    assign capOvf  = !capDbz && (dvdAbs[2*W-1:W] >= dvsAbs);

    assign shifted = {partial_q[W-1:0], dvdLow_q[W-1]};
    assign geq     = (shifted >= {1'b0, dvsMag_q});
    assign lateOvf = sq_q ? (qMag_q > MinNeg) : (qMag_q > MaxPos);

    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign overflow_o    = ovf_q;
    assign div_by_zero_o = dbz_q;

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        quot_d    = quot_q;
        rem_d     = rem_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        sq_d      = sq_q;
        sr_d      = sr_q;
        excOvf_d  = excOvf_q;
        excDbz_d  = excDbz_q;
        partial_d = partial_q;
        dvdLow_d  = dvdLow_q;
        dvsMag_d  = dvsMag_q;
        qMag_d    = qMag_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sq_d      = dividend_i[2*W-1] ^ divisor_i[W-1];
                    sr_d      = dividend_i[2*W-1];
                    dvsMag_d  = dvsAbs;
                    // The upper half is already known to be below the divisor, so it seeds the partial remainder.
                    partial_d = {1'b0, dvdAbs[2*W-1:W]};
                    dvdLow_d  = dvdAbs[W-1:0];
                    qMag_d    = '0;
                    cnt_d     = '0;
                    excDbz_d  = capDbz;
                    excOvf_d  = capOvf;
                    state_d   = (capDbz || capOvf) ? FIN : CALC;
                end
            end
            CALC: begin
                partial_d = geq ? (shifted - {1'b0, dvsMag_q}) : shifted;
                qMag_d    = {qMag_q[W-2:0], geq};
                dvdLow_d  = {dvdLow_q[W-2:0], 1'b0};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (excDbz_q) begin
                    quot_d = sr_q ? MinNeg : MaxPos;
                    rem_d  = '0;
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b1;
                end else if (excOvf_q || lateOvf) begin
                    quot_d = sq_q ? MinNeg : MaxPos;
                    rem_d  = '0;
                    ovf_d  = 1'b1;
                    dbz_d  = 1'b0;
                end else begin
                    quot_d = sq_q ? -qMag_q : qMag_q;
                    rem_d  = sr_q ? -partial_q[W-1:0] : partial_q[W-1:0];
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
            sq_q      <= 1'b0;
            sr_q      <= 1'b0;
            excOvf_q  <= 1'b0;
            excDbz_q  <= 1'b0;
            partial_q <= '0;
            dvdLow_q  <= '0;
            dvsMag_q  <= '0;
            qMag_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
            dbz_q     <= dbz_d;
            sq_q      <= sq_d;
            sr_q      <= sr_d;
            excOvf_q  <= excOvf_d;
            excDbz_q  <= excDbz_d;
            partial_q <= partial_d;
            dvdLow_q  <= dvdLow_d;
            dvsMag_q  <= dvsMag_d;
            qMag_q    <= qMag_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_frac_dec_div.sv
// Self-checking bench for frac_dec_div: directed vector table, handshake/reset sequences,
// and random operands against a truncating-division model.
module tb_frac_dec_div;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        overflow;
    logic        divByZero;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [15:0] expQ;
        logic [15:0] expR;
        logic        expOvf;
        logic        expDbz;
        int          expLat;
    } vec_t;

    frac_dec_div #(.DATA_WIDTH(16)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .overflow_o    (overflow),
        .div_by_zero_o (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Launches one division, measures edges from capture to done, then checks the results.
    task automatic applyStimulus(input vec_t v, input bit checkPulse, input string tag);
        int lat;
        @(negedge clk);
        start    = 1'b1;
        dividend = v.dvd;
        divisor  = v.dvs;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        checkOutput({tag, " busy_after_start"}, 32'(busy), 32'd1);
        lat = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = e;
                break;
            end
        end
        if (lat == 0) begin
            checkOutput({tag, " done_timeout"}, 32'd0, 32'd1);
            return;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(v.expLat));
        checkOutput({tag, " busy_at_done"}, 32'(busy), 32'd0);
        checkOutput({tag, " quotient"}, 32'(quotient), 32'(v.expQ));
        checkOutput({tag, " remainder"}, 32'(remainder), 32'(v.expR));
        checkOutput({tag, " div_by_zero"}, 32'(divByZero), 32'(v.expDbz));
        if (!v.expDbz) begin
            checkOutput({tag, " overflow"}, 32'(overflow), 32'(v.expOvf));
        end
        if (checkPulse) begin
            @(posedge clk);
            #1;
            checkOutput({tag, " done_pulse_width"}, 32'(done), 32'd0);
            checkOutput({tag, " quotient_hold"}, 32'(quotient), 32'(v.expQ));
        end
    endtask

    // Truncating signed division with saturation and the early-exception latency rule.
    function automatic vec_t model(input logic [31:0] a, input logic [15:0] b);
        vec_t   v;
        longint sa;
        longint sb;
        longint ma;
        longint mb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        v.dvd    = a;
        v.dvs    = b;
        v.expOvf = 1'b0;
        v.expDbz = 1'b0;
        if (sb == 0) begin
            v.expDbz = 1'b1;
            q = (sa < 0) ? -32768 : 32767;
            r = 0;
            v.expLat = 1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            v.expLat = ((ma >> 16) >= mb) ? 1 : 17;
            if (q > 32767 || q < -32768) begin
                v.expOvf = 1'b1;
                q = ((sa < 0) != (sb < 0)) ? -32768 : 32767;
                r = 0;
            end
        end
        v.expQ = q[15:0];
        v.expR = r[15:0];
        return v;
    endfunction

    initial begin
        vec_t table_v[14];
        vec_t v;
        int   lat;
        bit   sawDone;

        table_v[0]  = '{32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 17};
        table_v[1]  = '{32'hFFFF_FF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17};
        table_v[2]  = '{32'h0000_0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 17};
        table_v[3]  = '{32'hFFFF_FF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 17};
        table_v[4]  = '{32'hFFFF_0000, 16'h0002, 16'h8000, 16'h0000, 1'b0, 1'b0, 17};
        table_v[5]  = '{32'h0001_0000, 16'h0002, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 17};
        table_v[6]  = '{32'h4000_0000, 16'h0002, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1};
        table_v[7]  = '{32'h0000_04D2, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 1};
        table_v[8]  = '{32'hFFFF_FFFB, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b1, 1};
        table_v[9]  = '{32'h8000_0000, 16'h8000, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1};
        table_v[10] = '{32'h0000_0007, 16'h0064, 16'h0000, 16'h0007, 1'b0, 1'b0, 17};
        table_v[11] = '{32'hFFFF_FFF9, 16'h0064, 16'h0000, 16'hFFF9, 1'b0, 1'b0, 17};
        table_v[12] = '{32'hFFFF_FFFF, 16'h8000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 17};
        table_v[13] = '{32'h7FFF_FFFF, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset quotient", 32'(quotient), 32'd0);
        checkOutput("reset remainder", 32'(remainder), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset div_by_zero", 32'(divByZero), 32'd0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(table_v[i], 1'b1, $sformatf("vec%0d", i));
        end

        // A start pulse mid-calculation must not disturb the in-flight 100/7.
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            start    = (e == 3);
            dividend = 32'd1000;
            divisor  = 16'd3;
            @(posedge clk);
            #1;
            if (done) begin
                lat = e;
                break;
            end
        end
        start = 1'b0;
        checkOutput("busy_start latency", 32'(lat), 32'd17);
        checkOutput("busy_start quotient", 32'(quotient), 32'd14);
        checkOutput("busy_start remainder", 32'(remainder), 32'd2);

        // Back-to-back: the second start lands in the done cycle of the first.
        applyStimulus(table_v[0], 1'b0, "b2b_first");
        applyStimulus(table_v[3], 1'b1, "b2b_second");

        // Reset in the middle of CALC clears results and suppresses done.
        applyStimulus(table_v[0], 1'b1, "pre_reset");
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset quotient", 32'(quotient), 32'd0);
        checkOutput("midreset remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        sawDone = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done || busy) sawDone = 1'b1;
        end
        checkOutput("midreset no_done", 32'(sawDone), 32'd0);

        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a;
            logic [15:0] b;
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = 32'($signed($urandom) >>> $urandom_range(8, 31));
                2: a = 32'($signed(16'($urandom))) * 32'($urandom_range(0, 40000));
                default: a = 32'($signed($urandom) >>> 15);
            endcase
            case ($urandom_range(0, 9))
                0: b = 16'h0000;
                1: b = 16'h8000;
                2: b = 16'($urandom_range(1, 8));
                3: b = -16'($urandom_range(1, 8));
                default: b = 16'($urandom);
            endcase
            v = model(a, b);
            applyStimulus(v, 1'b0, $sformatf("rand%0d a=0x%0h b=0x%0h", i, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
